// File: rtl/div_unit.sv
// div_unit: multi-cycle 32-bit integer divider for DIV.W, MOD.W, DIV.WU and MOD.WU.
// A radix-2 restoring engine produces one quotient bit per cycle for 32 cycles.
// Fixed latency: accept in cycle 0, result valid from cycle 33.
//
// Ports:
//   clk        - clock, rising edge
//   resetn     - asynchronous active-low reset
//   div_valid  - request valid; div_ready - request accepted when both high
//   div_op     - 00 DIV.W, 01 MOD.W, 10 DIV.WU, 11 MOD.WU
//   div_src1   - dividend (rj); div_src2 - divisor (rk)
//   div_cancel - flush; aborts the operation in any state
//   res_valid  - result valid; res_ready - result consumed when both high
//   div_result - quotient or remainder, held until the next result
//   busy       - high while an operation is in flight or its result is pending
module div_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        div_valid,
  output logic        div_ready,
  input  logic [1:0]  div_op,
  input  logic [31:0] div_src1,
  input  logic [31:0] div_src2,
  input  logic        div_cancel,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] div_result,
  output logic        busy
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state;
  logic                is_signed;
  logic                sel_rem;
  logic                sign1;
  logic                sign2;
  logic                zero_div;
  logic [DATA_W-1:0]   src1_raw;
  logic [DATA_W-1:0]   dividend;
  logic [DATA_W-1:0]   divisor;
  logic [DATA_W-1:0]   quot;
  logic [DATA_W-1:0]   rem;
  logic [5:0]          cnt;

  logic [DATA_W:0]     rem_shift;
  logic [DATA_W:0]     rem_diff;
  logic [DATA_W-1:0]   rem_next;
  logic [DATA_W-1:0]   quot_next;
  logic                neg1;
  logic                neg2;

  // Two's-complement negate when requested; used for operand magnitude and sign fixup.
  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v, input logic neg);
    logic signed [DATA_W-1:0] sv;
    sv = v;
    return neg ? DATA_W'(-sv) : v;
  endfunction

  // Final result selection. A zero divisor overrides any sign correction.
  // 0x8000_0000 / -1 needs no special case: the magnitude quotient 0x8000_0000
  // negates back to itself and the remainder is zero.
  function automatic logic [DATA_W-1:0] final_result(
    input logic [DATA_W-1:0] q,
    input logic [DATA_W-1:0] r,
    input logic [DATA_W-1:0] src1,
    input logic              rem_sel,
    input logic              s1,
    input logic              s2,
    input logic              zdiv
  );
    if (zdiv)
      return rem_sel ? src1 : {DATA_W{1'b1}};
    else if (rem_sel)
      return cond_neg(r, s1);
    else
      return cond_neg(q, s1 ^ s2);
  endfunction

  assign div_ready = (state == IDLE);
  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // Operand signs only matter for the signed ops.
  assign neg1 = ~div_op[1] & div_src1[DATA_W-1];
  assign neg2 = ~div_op[1] & div_src2[DATA_W-1];

  // One restoring step. The partial remainder is always below the divisor,
  // so it fits in 32 bits; the shifted value and trial difference need 33.
  always_comb begin
    rem_shift = {rem, dividend[DATA_W-1]};
    rem_diff  = rem_shift - {1'b0, divisor};
    rem_next  = rem_shift[DATA_W-1:0];
    quot_next = {quot[DATA_W-2:0], 1'b0};
    if (!rem_diff[DATA_W]) begin
      rem_next  = rem_diff[DATA_W-1:0];
      quot_next = {quot[DATA_W-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      is_signed  <= 1'b0;
      sel_rem    <= 1'b0;
      sign1      <= 1'b0;
      sign2      <= 1'b0;
      zero_div   <= 1'b0;
      src1_raw   <= '0;
      dividend   <= '0;
      divisor    <= '0;
      quot       <= '0;
      rem        <= '0;
      cnt        <= '0;
      div_result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (div_valid && !div_cancel) begin
            state     <= CALC;
            is_signed <= ~div_op[1];
            sel_rem   <= div_op[0];
            sign1     <= neg1;
            sign2     <= neg2;
            zero_div  <= (div_src2 == '0);
            src1_raw  <= div_src1;
            dividend  <= cond_neg(div_src1, neg1);
            divisor   <= cond_neg(div_src2, neg2);
            quot      <= '0;
            rem       <= '0;
            cnt       <= '0;
          end
        end
        // ---- iteration stage: one quotient bit per cycle, MSB first ----
        CALC: begin
          if (div_cancel) begin
            state <= IDLE;
          end else begin
            rem      <= rem_next;
            quot     <= quot_next;
            dividend <= {dividend[DATA_W-2:0], 1'b0};
            cnt      <= cnt + 6'd1;
            if (cnt == 6'd31) begin
              state      <= DONE;
              div_result <= final_result(quot_next, rem_next, src1_raw, sel_rem,
                                         sign1 & is_signed, sign2 & is_signed, zero_div);
            end
          end
        end
        // ---- result stage: hold until consumed or flushed ----
        DONE: begin
          if (div_cancel || res_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        div_valid;
  logic        div_ready;
  logic [1:0]  div_op;
  logic [31:0] div_src1;
  logic [31:0] div_src2;
  logic        div_cancel;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] div_result;
  logic        busy;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  div_unit dut (
    .clk        (clk),
    .resetn     (resetn),
    .div_valid  (div_valid),
    .div_ready  (div_ready),
    .div_op     (div_op),
    .div_src1   (div_src1),
    .div_src2   (div_src2),
    .div_cancel (div_cancel),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .div_result (div_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: LoongArch divide semantics from plain integer arithmetic.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] sr;
    if (b == 32'd0) return op[0] ? a : 32'hFFFF_FFFF;
    if (op[1]) return op[0] ? (a % b) : (a / b);
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[0] ? 32'd0 : 32'h8000_0000;
    sa = a;
    sb = b;
    sr = op[0] ? (sa % sb) : (sa / sb);
    return sr;
  endfunction

  // Issue a request at a negedge, scramble inputs after accept, wait for the
  // result and check latency and value. Leaves the DUT in DONE.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    int n;
    logic [31:0] exp;
    exp = ref_div(op, a, b);
    check({tag, "/ready"}, 32'(div_ready), 32'd1);
    div_valid = 1'b1;
    div_op    = op;
    div_src1  = a;
    div_src2  = b;
    @(negedge clk);
    div_valid = 1'b0;
    div_src1  = $urandom;
    div_src2  = $urandom;
    div_op    = 2'($urandom);
    n = 1;
    while (!res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "/latency"}, 32'(n), 32'd33);
    check({tag, "/result"}, div_result, exp);
  endtask

  task automatic finish_op(input string tag);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, "/ready_after"}, 32'(div_ready), 32'd1);
    check({tag, "/valid_after"}, 32'(res_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] held;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [1:0]  rop;
    int          seen;

    resetn     = 1'b0;
    div_valid  = 1'b0;
    div_op     = 2'd0;
    div_src1   = 32'd0;
    div_src2   = 32'd0;
    div_cancel = 1'b0;
    res_ready  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset/div_ready", 32'(div_ready), 32'd1);
    check("reset/res_valid", 32'(res_valid), 32'd0);
    check("reset/busy", 32'(busy), 32'd0);
    check("reset/div_result", div_result, 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Directed values
    run_op(2'b10, 32'd7, 32'd2, "divwu_7_2");               finish_op("divwu_7_2");
    run_op(2'b11, 32'd7, 32'd2, "modwu_7_2");               finish_op("modwu_7_2");
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, "divw_m7_2");       finish_op("divw_m7_2");
    run_op(2'b01, 32'hFFFF_FFF9, 32'd2, "modw_m7_2");       finish_op("modw_m7_2");
    run_op(2'b00, 32'hFFFF_FFF9, 32'hFFFF_FFFE, "divw_m7_m2"); finish_op("divw_m7_m2");
    run_op(2'b01, 32'hFFFF_FFF9, 32'hFFFF_FFFE, "modw_m7_m2"); finish_op("modw_m7_m2");
    for (int i = 0; i < 4; i++) begin
      run_op(2'(i), 32'h1234_5678, 32'd0, "zero_div");
      finish_op("zero_div");
    end
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, "divw_ovf");  finish_op("divw_ovf");
    run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, "modw_ovf");  finish_op("modw_ovf");
    run_op(2'b10, 32'hFFFF_FFFF, 32'd1, "divwu_max_1");       finish_op("divwu_max_1");

    // Backpressure: result held, pending request not accepted
    run_op(2'b00, 32'd1000, 32'hFFFF_FFF3, "bp");
    held      = div_result;
    div_valid = 1'b1;
    div_op    = 2'b10;
    div_src1  = 32'd5;
    div_src2  = 32'd1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp/res_valid", 32'(res_valid), 32'd1);
      check("bp/div_result", div_result, held);
      check("bp/div_ready", 32'(div_ready), 32'd0);
    end
    div_valid = 1'b0;
    finish_op("bp");

    // Cancel in CALC cycle 10
    div_valid = 1'b1;
    div_op    = 2'b10;
    div_src1  = 32'd50;
    div_src2  = 32'd3;
    @(negedge clk);
    div_valid = 1'b0;
    repeat (9) @(negedge clk);
    div_cancel = 1'b1;
    @(negedge clk);
    div_cancel = 1'b0;
    check("cancel_calc/busy", 32'(busy), 32'd0);
    check("cancel_calc/res_valid", 32'(res_valid), 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (res_valid) seen++;
    end
    check("cancel_calc/no_result", 32'(seen), 32'd0);
    run_op(2'b10, 32'd100, 32'd7, "after_cancel");  finish_op("after_cancel");

    // Cancel with request in IDLE: no accept
    div_valid  = 1'b1;
    div_cancel = 1'b1;
    @(negedge clk);
    div_valid  = 1'b0;
    div_cancel = 1'b0;
    check("cancel_idle/busy", 32'(busy), 32'd0);
    check("cancel_idle/div_ready", 32'(div_ready), 32'd1);

    // Cancel together with res_ready in DONE
    run_op(2'b11, 32'd29, 32'd5, "cancel_done");
    div_cancel = 1'b1;
    res_ready  = 1'b1;
    @(negedge clk);
    div_cancel = 1'b0;
    res_ready  = 1'b0;
    check("cancel_done/res_valid", 32'(res_valid), 32'd0);
    check("cancel_done/busy", 32'(busy), 32'd0);

    // Asynchronous reset in CALC cycle 20
    div_valid = 1'b1;
    div_op    = 2'b00;
    div_src1  = 32'd12345;
    div_src2  = 32'd17;
    @(negedge clk);
    div_valid = 1'b0;
    repeat (19) @(negedge clk);
    check("rst_mid/busy_before", 32'(busy), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("rst_mid/div_ready", 32'(div_ready), 32'd1);
    check("rst_mid/res_valid", 32'(res_valid), 32'd0);
    check("rst_mid/busy", 32'(busy), 32'd0);
    check("rst_mid/div_result", div_result, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    run_op(2'b00, 32'd12345, 32'd17, "after_rst");  finish_op("after_rst");

    // Randomized operations against the reference
    for (int i = 0; i < 20; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = 32'(-int'($urandom_range(1, 15)));
        3:       ra = 32'h8000_0000;
        default: rb = $urandom;
      endcase
      if (ra == 32'h8000_0000 && $urandom_range(0, 1) == 1) rb = 32'hFFFF_FFFF;
      run_op(rop, ra, rb, "random");
      finish_op("random");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
